// File: rtl/uart_rx_port_if.sv
// CPU-side bus bundle for uart_rx_port: address/strobes/write data in, read data and hit out.
interface uart_rx_port_if;
   logic [15:0] addressBus;
   logic        writeEnBus;
   logic        readEnBus;
   logic [7:0]  data_c2r;
   logic [7:0]  data_r2c;
   logic        hit;

   modport master (output addressBus, writeEnBus, readEnBus, data_c2r,
                   input  data_r2c, hit);
   modport slave  (input  addressBus, writeEnBus, readEnBus, data_c2r,
                   output data_r2c, hit);
endinterface

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 serial receiver with a small receive FIFO, data at BASE_ADDR, status at BASE_ADDR+1.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity errors in status bit 4.
module uart_rx_port #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] BASE_ADDR    = 16'h5a00
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           rx,
   uart_rx_port_if.slave  bus,
   output logic           rx_irq
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

   logic [1:0]    sync_q;
   logic          rx_prev_q;
   logic          rx_s;
   state_t        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          push, frame_set, par_set;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          empty, full, pop, push_ok, ovr_set;
   logic          rd_data, rd_stat, wr_stat;
   logic          ovr_q, ovr_d, frame_q, frame_d, par_flag;
   logic [7:0]    status, data_q, data_d;
   logic          hit_q, hit_d;
   logic          unused_bits;

   // Line is idle high, so the synchroniser presets to 1 to avoid a false start after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], rx};
         rx_prev_q <= sync_q[1];
      end
   end
   assign rx_s = sync_q[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      frame_set = 1'b0;
      par_set   = 1'b0;
      unique case (state_q)
         S_IDLE: if (rx_prev_q && !rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
         end
         S_START: if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
         end else cnt_d = cnt_q + 1'b1;
         S_DATA: if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_d = S_PARITY;
`else
            if (bit_q == 3'd7) state_d = S_STOP;
`endif
         end else cnt_d = cnt_q + 1'b1;
         S_PARITY: if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            par_set = (^shreg_q) != rx_s;
            state_d = S_STOP;
         end else cnt_d = cnt_q + 1'b1;
         S_STOP: if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (rx_s) begin
               push    = 1'b1;
               state_d = S_IDLE;
            end else begin
               frame_set = 1'b1;
               state_d   = S_BRK;
            end
         end else cnt_d = cnt_q + 1'b1;
         // A held-low line parks here so it reports only one framing error.
         S_BRK: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign rd_data = bus.readEnBus  && (bus.addressBus == BASE_ADDR);
   assign rd_stat = bus.readEnBus  && (bus.addressBus == BASE_ADDR + 16'd1);
   assign wr_stat = bus.writeEnBus && (bus.addressBus == BASE_ADDR + 16'd1);

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign pop     = rd_data && !empty;
   assign push_ok = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (!push_ok && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Set wins over a same-cycle write-one-to-clear.
   assign ovr_d   = ovr_set   | (ovr_q   & ~(wr_stat & bus.data_c2r[1]));
   assign frame_d = frame_set | (frame_q & ~(wr_stat & bus.data_c2r[2]));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovr_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         ovr_q   <= ovr_d;
         frame_q <= frame_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_q, par_d;
   assign par_d = par_set | (par_q & ~(wr_stat & bus.data_c2r[4]));
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) par_q <= 1'b0;
      else        par_q <= par_d;
   end
   assign par_flag    = par_q;
   assign unused_bits = ^{bus.data_c2r[7:5], bus.data_c2r[3], bus.data_c2r[0]};
`else
   assign par_flag    = 1'b0;
   assign unused_bits = ^{bus.data_c2r[7:3], bus.data_c2r[0], par_set};
`endif

   assign status = {3'b000, par_flag, full, frame_q, ovr_q, !empty};

   always_comb begin
      data_d = data_q;
      if (rd_data)      data_d = empty ? 8'h00 : mem_q[rd_ptr_q];
      else if (rd_stat) data_d = status;
   end
   assign hit_d = rd_data | rd_stat;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_q <= 8'h00;
         hit_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         hit_q  <= hit_d;
      end
   end

   assign bus.data_r2c = data_q;
   assign bus.hit      = hit_q;
   assign rx_irq       = !empty;
endmodule

// File: tb/tb_uart_rx_port.sv
// Scoreboarded bench for uart_rx_port: reads push expectations, a negedge monitor checks each hit.
module tb_uart_rx_port;
   localparam int          CPB = 16;
   localparam logic [15:0] DA  = 16'h5a00;
   localparam logic [15:0] SA  = 16'h5a01;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic rx    = 1'b1;
   logic rx_irq;
   int   checks = 0;
   int   errors = 0;
   int   rd_idx = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mon_exp;

   uart_rx_port_if bus ();

   uart_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .BASE_ADDR(DA)) dut (
      .clock (clock),
      .reset (reset),
      .rx    (rx),
      .bus   (bus),
      .rx_irq(rx_irq)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset && bus.hit) begin
         if (exp_q.size() == 0) chk("unexpected_hit", 32'd1, 32'd0);
         else begin
            mon_exp = exp_q.pop_front();
            chk($sformatf("read%0d", rd_idx), {24'd0, bus.data_r2c}, {24'd0, mon_exp});
         end
         rd_idx++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic cpu_read(input logic [15:0] a, input logic [7:0] e);
      @(posedge clock); #1;
      bus.addressBus = a;
      bus.readEnBus  = 1'b1;
      exp_q.push_back(e);
      @(posedge clock); #1;
      bus.readEnBus  = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(posedge clock); #1;
      bus.addressBus = a;
      bus.data_c2r   = d;
      bus.writeEnBus = 1'b1;
      @(posedge clock); #1;
      bus.writeEnBus = 1'b0;
   endtask

   task automatic bit_out(input logic v);
      rx = v;
      repeat (CPB) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic pflip);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
      bit_out((^b) ^ pflip);
`endif
      bit_out(stop_v);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic seen;
      bus.addressBus = '0;
      bus.writeEnBus = 1'b0;
      bus.readEnBus  = 1'b0;
      bus.data_c2r   = '0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      chk("rst_data", {24'd0, bus.data_r2c}, 32'h00);
      chk("rst_hit", {31'd0, bus.hit}, 32'd0);
      chk("rst_irq", {31'd0, rx_irq}, 32'd0);
      cpu_read(SA, 8'h00);

      // Single byte, interrupt latency from the start edge.
      n = 0; seen = 1'b0;
      fork
         send_frame(8'h41, 1'b1, 1'b0);
         begin
            for (int k = 0; k < 300 && !seen; k++) begin
               @(negedge clock);
               n = k + 1;
               if (rx_irq) seen = 1'b1;
            end
         end
      join
      chk($sformatf("irq_latency n=%0d", n),
          {31'd0, seen && n >= CPB * 9 + 2 && n <= CPB * 11 + 16}, 32'd1);
      cpu_read(SA, 8'h01);
      cpu_read(DA, 8'h41);
      cpu_read(SA, 8'h00);
      idle(2);
      chk("irq_after_drain", {31'd0, rx_irq}, 32'd0);

      // Overrun: five bytes into a four-deep FIFO.
      for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
      idle(4);
      cpu_read(SA, 8'h0B);
      for (int i = 0; i < 4; i++) cpu_read(DA, 8'h10 + 8'(i));
      cpu_read(DA, 8'h00);
      cpu_read(SA, 8'h02);
      cpu_write(SA, 8'h02);
      cpu_read(SA, 8'h00);

      // Short glitch must not start a frame; the next real frame still lands.
      rx = 1'b0;
      repeat (3) @(posedge clock);
      #1 rx = 1'b1;
      idle(40);
      cpu_read(SA, 8'h00);
      chk("glitch_irq", {31'd0, rx_irq}, 32'd0);
      send_frame(8'h5A, 1'b1, 1'b0);
      idle(4);
      cpu_read(DA, 8'h5A);

      // Framing error followed by a held-low line, then a good byte.
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (100) @(posedge clock);
      #1 rx = 1'b1;
      idle(40);
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(4);
      cpu_read(SA, 8'h05);
      cpu_read(DA, 8'hA5);
      cpu_read(SA, 8'h04);
      cpu_read(DA, 8'h00);
      cpu_write(SA, 8'h04);
      cpu_read(SA, 8'h00);

      // Asynchronous reset in the middle of a data phase with two bytes queued.
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      idle(4);
      cpu_read(SA, 8'h01);
      idle(2);
      chk("pre_reset_irq", {31'd0, rx_irq}, 32'd1);
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b1);
      repeat (4) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("mid_rst_data", {24'd0, bus.data_r2c}, 32'h00);
      chk("mid_rst_hit", {31'd0, bus.hit}, 32'd0);
      chk("mid_rst_irq", {31'd0, rx_irq}, 32'd0);
      rx = 1'b1;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      idle(40);
      chk("post_rst_irq", {31'd0, rx_irq}, 32'd0);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(4);
      cpu_read(DA, 8'h3C);
      cpu_read(DA, 8'h00);

      // Wrong parity bit: flagged only when parity is built, byte kept either way.
      send_frame(8'h07, 1'b1, 1'b1);
      idle(4);
`ifdef UART_RX_PARITY_EN
      cpu_read(SA, 8'h11);
      cpu_read(DA, 8'h07);
      cpu_read(SA, 8'h10);
`else
      cpu_read(SA, 8'h01);
      cpu_read(DA, 8'h07);
      cpu_read(SA, 8'h00);
`endif
      cpu_write(SA, 8'h10);
      cpu_read(SA, 8'h00);

      idle(4);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Memory-mapped serial receiver: the CPU6-side input counterpart of the write-only console transmit register at 16'h5a00.
- Deserialises 8N1 frames from a serial line into a small FIFO.
- The CPU reads received bytes and status over the same address/data bus used by Memory.
- Sits beside Memory on addressBus; the top level muxes its read data when its hit output is high.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- BASE_ADDR, 16'h5a00, data register address; status register is at BASE_ADDR+1.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clock.
- addressBus  input  16  CPU address.
- writeEnBus  input  1  CPU write strobe.
- readEnBus  input  1  CPU read strobe, one cycle per read access.
- data_c2r  input  8  CPU write data.
- data_r2c  output  8  registered read data.
- hit  output  1  registered; high when the previous cycle's readEnBus targeted BASE_ADDR or BASE_ADDR+1.
- rx_irq  output  1  high while the FIFO is non-empty.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE; FIFO is emptied.
  - data_r2c=8'h00, hit=0, rx_irq=0; overrun and framing flags cleared.
  - Synchroniser flops preset to 1.
- Synchroniser:
  - rx passes through 2 flops before use.
  - The FSM sees only the synchronised value; 2 cycles of added latency.
- FSM states:
  - IDLE: on a synchronised 1->0 transition, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. Low -> DATA. High -> glitch, back to IDLE with no flag set.
  - DATA: sample every CLKS_PER_BIT cycles. 8 samples, LSB first, shifted into the shift register. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. High -> push the byte and go to IDLE. Low -> set the framing flag, discard the byte, go to BREAK.
  - BREAK: stay until the synchronised rx is high, then go to IDLE. A held-low line yields exactly one framing error.
- FIFO:
  - Push into a full FIFO with no pop in the same cycle: drop the new byte, keep contents, set the sticky overrun flag.
  - Push and pop in the same cycle: both happen. On a full FIFO this is not an overrun.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Reads, registered with one-cycle latency like Memory:
  - On posedge with readEnBus=1 and addressBus=BASE_ADDR: data_r2c <= FIFO head; pop if non-empty. Reading an empty FIFO returns 8'h00 and does not pop.
  - On posedge with readEnBus=1 and addressBus=BASE_ADDR+1: data_r2c <= status.
  - Status bits: {3'b0, parity_err, full, framing, overrun, ready}. ready = FIFO non-empty.
  - Status reflects the flags as they stand before that edge's updates.
  - hit <= readEnBus && address matches. Otherwise hit <= 0 and data_r2c holds its value.
- Writes:
  - writeEnBus=1 at BASE_ADDR+1: each status bit 1..2 (and 4 when parity is built) written as 1 clears that flag.
  - A flag set in the same cycle as its clear stays set (set wins).
  - Writes to BASE_ADDR are ignored; 16'h5a00 writes stay with the transmit side.
- rx_irq is combinational from the FIFO count.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state sits between DATA and STOP.
  - Even parity mismatch sets sticky status bit 4 (parity_err). The byte is still pushed.
- Undefined:
  - 8N1 only; status bit 4 reads 0; writes to bit 4 have no effect.

Test Plan:
- Send 8'h41 at CLKS_PER_BIT=16 -> rx_irq rises ~162 cycles after the start edge. Status read = 8'h01. Data read = 8'h41. Next status read = 8'h00 and rx_irq=0.
- Send 5 bytes 8'h10..8'h14 without reading (FIFO_DEPTH=4) -> status = 8'h0B (full, overrun, ready). Reads return 8'h10..8'h13, then a 5th read returns 8'h00. Writing 8'h02 to 16'h5a01 clears overrun.
- 3-cycle low pulse on rx while IDLE -> no push, no flags, FSM back in IDLE.
- Frame 8'h55 with stop bit low, then line held low 100 cycles, then high, then valid 8'hA5 -> framing flag set once; only 8'hA5 is in the FIFO.
- Assert reset mid-DATA with 2 bytes queued -> FIFO empty, rx_irq=0, data_r2c=8'h00. The next full frame 8'h3C is received correctly.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit 0 -> status = 8'h11, data read = 8'h07. Without the macro, same bench at 8N1 -> status = 8'h01.
